// File: rtl/uart_frame_arbiter_if.sv
// Requester and transmitter signal bundle for uart_frame_arbiter.
// The arbiter is the slave; producers plus transmitter form the master side.
interface uart_frame_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64
);
    logic [NUM_REQ-1:0]            i_req;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_data;
    logic [NUM_REQ-1:0]            o_grant;
    logic [NUM_REQ-1:0]            o_ack;
    logic [NUM_REQ-1:0]            o_err;
    logic                          o_active;
    logic                          o_frame_request;
    logic [DATA_WIDTH-1:0]         o_frame_data;
    logic                          i_frame_busy;
    logic                          i_frame_done;

    modport master (
        output i_req, i_data, i_frame_busy, i_frame_done,
        input  o_grant, o_ack, o_err, o_active,
        input  o_frame_request, o_frame_data
    );

    modport slave (
        input  i_req, i_data, i_frame_busy, i_frame_done,
        output o_grant, o_ack, o_err, o_active,
        output o_frame_request, o_frame_data
    );
endinterface

// File: rtl/uart_frame_arbiter.sv
// Round-robin sharing of one UART frame transmitter among NUM_REQ producers,
// with per-owner ack on done and error pulse on timeout.
module uart_frame_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                clock,
    input  logic                reset,
    uart_frame_arbiter_if.slave bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         owner_q, owner_d;
    logic [PW-1:0]         rr_q, rr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;

    logic                  found;
    logic [PW-1:0]         win;
    logic [DATA_WIDTH-1:0] win_data;
    logic [PW:0]           idx;
    logic [NUM_REQ-1:0]    own_oh;

    // First pending requester at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        idx      = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_q} + (PW+1)'(i);
            if (idx >= (PW+1)'(NUM_REQ))
                idx = idx - (PW+1)'(NUM_REQ);
            if (!found && bus.i_req[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win == PW'(k))
                win_data = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (found && !bus.i_frame_busy) begin
                    owner_d = win;
                    data_d  = win_data;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                cnt_d = cnt_q + 1'b1;
                // Done takes precedence over a coincident timeout.
                if (bus.i_frame_done) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (owner_q == PW'(NUM_REQ - 1))
                    rr_d = '0;
                else
                    rr_d = owner_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign own_oh = NUM_REQ'(1) << owner_q;

    assign bus.o_grant = (state_q == ISSUE || state_q == WAIT_DONE)
                         ? own_oh : '0;
    assign bus.o_ack   = (state_q == DONE && !err_q) ? own_oh : '0;
    assign bus.o_err   = (state_q == DONE && err_q) ? own_oh : '0;
    assign bus.o_active        = (state_q != IDLE);
    assign bus.o_frame_request = (state_q == ISSUE);
    assign bus.o_frame_data    = data_q;
endmodule
